// File: rtl/apb_bus_fanjunling_pkg.sv
// Shared constants, widths and APB phase decode for the apb_bus_fanjunling flag block.
package apb_bus_fanjunling_pkg;

  localparam int ADDR_W = 5;
  localparam int N_DATA = 16;
  localparam int N_IRQ  = 8;

  localparam logic [ADDR_W-1:0] DATA_BASE = 5'h00;
  localparam logic [ADDR_W-1:0] IE_BASE   = 5'h10;
  localparam logic [ADDR_W-1:0] IS_BASE   = 5'h18;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} phase_e;

  function automatic phase_e apb_phase(input logic psel, input logic penable);
    if (!psel) return IDLE;
    return penable ? ACCESS : SETUP;
  endfunction

endpackage

// File: rtl/apb_bus_fanjunling_irq.sv
// Interrupt enable/status bits, change-event detection on DATA[7:0] and the INT_B register.
module apb_bus_fanjunling_irq
  import apb_bus_fanjunling_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ev_wr,
  input  logic             ie_wr,
  input  logic             is_wr,
  input  logic [2:0]       idx,
  input  logic             wdata,
  input  logic [N_IRQ-1:0] data_lo,
  output logic [N_IRQ-1:0] ie,
  output logic [N_IRQ-1:0] is,
  output logic             int_b
);

  logic [N_IRQ-1:0] set, clr;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_bit
    logic hit;
    assign hit    = (idx == 3'(i));
    assign set[i] = ev_wr & hit & (data_lo[i] ^ wdata);
    assign clr[i] = is_wr & hit & wdata;
  end

  // set is OR'd in last so a simultaneous set beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie    <= '0;
      is    <= '0;
      int_b <= 1'b1;
    end else begin
      if (ie_wr) ie[idx] <= wdata;
      is    <= (is & ~clr) | set;
      int_b <= ~|(is & ie);
    end
  end

endmodule

// File: rtl/apb_bus_fanjunling.sv
// 1-bit APB slave: phase decode, DATA register file, registered read port; IRQ logic in a sub-module.
module apb_bus_fanjunling
  import apb_bus_fanjunling_pkg::*;
(
  input  logic              SYSCLK,
  input  logic              RST_B,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PWDATA,
  output logic              PRDATA,
  output logic              INT_B
);

  phase_e            phase;
  logic              setup_q;
  logic              wr_en, rd_setup;
  logic              sel_data, sel_ie, sel_is;
  logic              rd_bit;
  logic [N_DATA-1:0] data_q;
  logic [N_IRQ-1:0]  ie, is;

  assign phase = apb_phase(PSEL, PENABLE);

  // An access only counts when the previous cycle was a setup; this also
  // drops an access left dangling across a reset release.
  always_ff @(posedge SYSCLK or posedge RST_B) begin
    if (RST_B) setup_q <= 1'b0;
    else       setup_q <= (phase == SETUP);
  end

  assign wr_en    = (phase == ACCESS) && setup_q && PWRITE;
  assign rd_setup = (phase == SETUP) && !PWRITE;

  assign sel_data = (PADDR[4]   == DATA_BASE[4]);
  assign sel_ie   = (PADDR[4:3] == IE_BASE[4:3]);
  assign sel_is   = (PADDR[4:3] == IS_BASE[4:3]);

  always_ff @(posedge SYSCLK or posedge RST_B) begin
    if (RST_B)                data_q <= '0;
    else if (wr_en && sel_data) data_q[PADDR[3:0]] <= PWDATA;
  end

  always_comb begin
    rd_bit = 1'b0;
    if (sel_data)    rd_bit = data_q[PADDR[3:0]];
    else if (sel_ie) rd_bit = ie[PADDR[2:0]];
    else if (sel_is) rd_bit = is[PADDR[2:0]];
  end

  always_ff @(posedge SYSCLK or posedge RST_B) begin
    if (RST_B) PRDATA <= 1'b0;
    else       PRDATA <= rd_setup ? rd_bit : 1'b0;
  end

  apb_bus_fanjunling_irq u_irq (
    .clk     (SYSCLK),
    .rst     (RST_B),
    .ev_wr   (wr_en && (PADDR[4:3] == DATA_BASE[4:3])),
    .ie_wr   (wr_en && sel_ie),
    .is_wr   (wr_en && sel_is),
    .idx     (PADDR[2:0]),
    .wdata   (PWDATA),
    .data_lo (data_q[N_IRQ-1:0]),
    .ie      (ie),
    .is      (is),
    .int_b   (INT_B)
  );

endmodule

// File: tb/tb_apb_bus_fanjunling.sv
// Directed bench for apb_bus_fanjunling: APB writes/reads, interrupt set/clear/mask, reset abort.
module tb_apb_bus_fanjunling;

  logic       SYSCLK = 1'b0;
  logic       RST_B  = 1'b1;
  logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, PWDATA = 1'b0;
  logic [4:0] PADDR = 5'h00;
  logic       PRDATA, INT_B;

  int checks = 0;
  int errors = 0;

  apb_bus_fanjunling dut (
    .SYSCLK(SYSCLK), .RST_B(RST_B), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .INT_B(INT_B)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Called at a negedge; returns at the negedge after the commit edge.
  task automatic apb_write(input logic [4:0] a, input logic d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge SYSCLK); PENABLE = 1'b1;
    @(negedge SYSCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = 1'b0;
  endtask

  // acc_v: PRDATA during access phase; aft_v: PRDATA the cycle after.
  task automatic apb_read(input logic [4:0] a, output logic acc_v, output logic aft_v);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge SYSCLK); acc_v = PRDATA; PENABLE = 1'b1;
    @(negedge SYSCLK); aft_v = PRDATA; PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic chk_read(input string name, input logic [4:0] a, input logic exp);
    logic acc_v, aft_v;
    apb_read(a, acc_v, aft_v);
    checks++;
    if (acc_v !== exp) begin
      errors++; $display("FAIL %s addr=%0h PRDATA=%b expected=%b", name, a, acc_v, exp);
    end
    checks++;
    if (aft_v !== 1'b0) begin
      errors++; $display("FAIL %s_after addr=%0h PRDATA=%b expected=0", name, a, aft_v);
    end
  endtask

  task automatic chk_int(input string name, input logic exp);
    checks++;
    if (INT_B !== exp) begin
      errors++; $display("FAIL %s INT_B=%b expected=%b", name, INT_B, exp);
    end
  endtask

  task automatic test_reset();
    RST_B = 1'b1;
    repeat (3) @(negedge SYSCLK);
    checks++;
    if (PRDATA !== 1'b0) begin errors++; $display("FAIL reset_prdata PRDATA=%b expected=0", PRDATA); end
    chk_int("reset_int", 1'b1);
    RST_B = 1'b0;
    @(negedge SYSCLK);
    chk_read("reset_data0", 5'h00, 1'b0);
    chk_read("reset_ie0",   5'h10, 1'b0);
    chk_read("reset_is0",   5'h18, 1'b0);
  endtask

  task automatic test_data_rw();
    apb_write(5'h05, 1'b1);
    chk_read("data05", 5'h05, 1'b1);
    chk_read("data06", 5'h06, 1'b0);
    apb_write(5'h0C, 1'b1);          // upper DATA bit: no interrupt source
    chk_read("data0c", 5'h0C, 1'b1);
    chk_read("is_after_0c", 5'h1C, 1'b0);
  endtask

  task automatic test_interrupt();
    apb_write(5'h13, 1'b1);
    chk_read("ie3", 5'h13, 1'b1);
    chk_int("ie_only", 1'b1);
    apb_write(5'h03, 1'b1);
    chk_int("irq_edge_T", 1'b1);
    @(negedge SYSCLK);
    chk_int("irq_edge_T1", 1'b0);
    chk_read("is3_set", 5'h1B, 1'b1);
  endtask

  task automatic test_clear();
    apb_write(5'h1B, 1'b0);
    @(negedge SYSCLK);
    chk_int("w0_no_clear", 1'b0);
    chk_read("is3_w0", 5'h1B, 1'b1);
    apb_write(5'h1B, 1'b1);
    chk_int("clr_edge_T", 1'b0);
    @(negedge SYSCLK);
    chk_int("clr_edge_T1", 1'b1);
    chk_read("is3_cleared", 5'h1B, 1'b0);
    apb_write(5'h03, 1'b1);           // same value: no event
    @(negedge SYSCLK);
    chk_int("same_val_noev", 1'b1);
    chk_read("is3_same_val", 5'h1B, 1'b0);
    apb_write(5'h03, 1'b0);           // 1->0 is also a change
    @(negedge SYSCLK);
    chk_int("fall_event", 1'b0);
    apb_write(5'h1B, 1'b1);
    @(negedge SYSCLK);
    chk_int("fall_cleared", 1'b1);
  endtask

  task automatic test_mask();
    apb_write(5'h02, 1'b1);
    @(negedge SYSCLK);
    chk_int("masked", 1'b1);
    chk_read("is2_masked", 5'h1A, 1'b1);
    apb_write(5'h12, 1'b1);
    chk_int("unmask_T", 1'b1);
    @(negedge SYSCLK);
    chk_int("unmask_T1", 1'b0);
    apb_write(5'h12, 1'b0);           // disabling IE also releases INT_B
    @(negedge SYSCLK);
    chk_int("ie_clear_T1", 1'b1);
    chk_read("is2_still", 5'h1A, 1'b1);
    apb_write(5'h1A, 1'b1);
    chk_read("is2_cleared", 5'h1A, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic acc_v;
    // write 0x09=1, then a read setup in the very next cycle
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h09; PWDATA = 1'b1;
    @(negedge SYSCLK); PENABLE = 1'b1;
    @(negedge SYSCLK); PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 5'h09;
    @(negedge SYSCLK); acc_v = PRDATA; PENABLE = 1'b1;
    checks++;
    if (acc_v !== 1'b1) begin errors++; $display("FAIL b2b_read PRDATA=%b expected=1", acc_v); end
    @(negedge SYSCLK); PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h0A; PWDATA = 1'b1;
    @(negedge SYSCLK); PENABLE = 1'b1;
    @(negedge SYSCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    chk_read("b2b_read_0a", 5'h0A, 1'b1);
  endtask

  task automatic test_robust();
    apb_write(5'h10, 1'b1);
    apb_write(5'h00, 1'b1);
    @(negedge SYSCLK);
    chk_int("pre_rst_irq", 1'b0);
    // reset lands mid access phase of a write to 0x0E
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h0E; PWDATA = 1'b1;
    @(negedge SYSCLK); PENABLE = 1'b1;
    #2 RST_B = 1'b1;
    #1 chk_int("async_rst_int", 1'b1);
    checks++;
    if (PRDATA !== 1'b0) begin errors++; $display("FAIL async_rst_prdata PRDATA=%b expected=0", PRDATA); end
    @(negedge SYSCLK);
    // release with an access (no setup) still on the bus to 0x08
    PADDR = 5'h08; RST_B = 1'b0;
    @(negedge SYSCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = 1'b0;
    chk_read("aborted_0e", 5'h0E, 1'b0);
    chk_read("rst_data05", 5'h05, 1'b0);
    chk_read("rst_data00", 5'h00, 1'b0);
    chk_read("rst_ie0",    5'h10, 1'b0);
    chk_read("rst_is0",    5'h18, 1'b0);
    chk_read("no_setup_08", 5'h08, 1'b0);
    // stray PENABLE without PSEL
    PSEL = 1'b0; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 5'h07; PWDATA = 1'b1;
    @(negedge SYSCLK); PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = 1'b0;
    @(negedge SYSCLK);
    chk_read("stray_pen_07", 5'h07, 1'b0);
    chk_int("end_int", 1'b1);
  endtask

  initial begin
    @(negedge SYSCLK);
    test_reset();
    test_data_rw();
    test_interrupt();
    test_clear();
    test_mask();
    test_back_to_back();
    test_robust();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
